// File: rtl/rotate_engine.sv
// rotate_engine: rotates an NxN piece and checks it against the board window, trying wall kicks.
// Define ROTATE_KICK_EN to try kick 1 (left) and kick 2 (right) after kick 0 collides.
module rotate_engine #(
  parameter int N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     direction,
  input  logic [0:N*N-1]           float,
  output logic [$clog2(N)-1:0]     win_row_addr,
  input  logic [N+1:0]             win_row_data,
  output logic                     busy,
  output logic                     done,
  output logic                     ok,
  output logic [0:N*N-1]           new_float,
  output logic [1:0]               kick
);
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N+1);
`ifdef ROTATE_KICK_EN
  localparam logic [1:0] LAST_ATT = 2'd2;
`else
  localparam logic [1:0] LAST_ATT = 2'd0;
`endif
  typedef enum logic [1:0] {IDLE, ROT, CHECK, DONE} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      att_q;
  logic            coll_q, pass_q, dir_q, busy_q, done_q, ok_q;
  logic [0:N*N-1]  orig_q, rot_q, nf_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      kick_q;
  logic [0:N*N-1]  rot_d;
  logic [AW-1:0]   rsel;
  logic [N-1:0]    row;
  logic [N+1:0]    mask;
  logic            hit, fail;
  always_comb begin
    rot_d = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        rot_d[r*N+c] = dir_q ? orig_q[c*N+N-1-r] : orig_q[(N-1-c)*N+r];
  end
  // count value k tests the row issued at k-1, whose data arrives now
  assign rsel = AW'(cnt_q - CW'(1));
  always_comb begin
    row = '0;
    for (int c = 0; c < N; c++) row[N-1-c] = rot_q[int'(rsel)*N+c];
    mask = att_q == 2'd1 ? {row, 2'b00} : att_q == 2'd2 ? {2'b00, row} : {1'b0, row, 1'b0};
    hit  = (cnt_q != '0) && |(mask & win_row_data);
    fail = coll_q | hit;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      att_q   <= '0;
      coll_q  <= 1'b0;
      pass_q  <= 1'b0;
      dir_q   <= 1'b0;
      orig_q  <= '0;
      rot_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      nf_q    <= '0;
      kick_q  <= '0;
    end else begin
      done_q <= 1'b0;
      addr_q <= (state_q == CHECK && cnt_q < CW'(N-1)) ? AW'(cnt_q + CW'(1)) : '0;
      case (state_q)
        IDLE: if (req) begin
          orig_q  <= float;
          dir_q   <= direction;
          busy_q  <= 1'b1;
          state_q <= ROT;
        end
        ROT: begin
          rot_q   <= rot_d;
          cnt_q   <= '0;
          att_q   <= '0;
          coll_q  <= 1'b0;
          state_q <= CHECK;
        end
        CHECK: if (cnt_q == CW'(N)) begin
          if (!fail || att_q == LAST_ATT) begin
            pass_q  <= !fail;
            state_q <= DONE;
          end else begin
            att_q  <= att_q + 2'd1;
            cnt_q  <= '0;
            coll_q <= 1'b0;
          end
        end else begin
          cnt_q  <= cnt_q + CW'(1);
          coll_q <= fail;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          ok_q    <= pass_q;
          kick_q  <= pass_q ? att_q : 2'd0;
          nf_q    <= pass_q ? rot_q : orig_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign win_row_addr = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign ok           = ok_q;
  assign new_float    = nf_q;
  assign kick         = kick_q;
endmodule

// File: tb/tb_rotate_engine.sv
// tb_rotate_engine: directed checks of rotate_engine with N=4 and a registered board-window model.
module tb_rotate_engine;
  localparam int N = 4;
`ifdef ROTATE_KICK_EN
  localparam bit KE = 1'b1;
`else
  localparam bit KE = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, direction = 1'b0;
  logic [0:15] float = '0;
  logic [1:0]  win_row_addr;
  logic [5:0]  win_row_data = '0;
  logic        busy, done, ok;
  logic [0:15] new_float;
  logic [1:0]  kick;
  logic [5:0]  win [4];
  int vectors = 0, miscompares = 0;

  rotate_engine #(.N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .direction(direction), .float(float),
    .win_row_addr(win_row_addr), .win_row_data(win_row_data), .busy(busy),
    .done(done), .ok(ok), .new_float(new_float), .kick(kick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) win_row_data <= win[win_row_addr];

  task automatic set_win(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c, input logic [5:0] d);
    win[0] = a; win[1] = b; win[2] = c; win[3] = d;
  endtask

  task automatic run_op(input logic [0:15] f, input logic d, output int cyc);
    float = f; direction = d; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset;
    set_win(6'd0, 6'd0, 6'd0, 6'd0);
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
    vectors++; if (ok !== 1'b0) begin miscompares++; $display("FAIL rst_ok got %b want 0", ok); end
    vectors++; if (kick !== 2'd0) begin miscompares++; $display("FAIL rst_kick got %0d want 0", kick); end
    vectors++; if (new_float !== 16'h0) begin miscompares++; $display("FAIL rst_nf got %b want 0", new_float); end
    vectors++; if (win_row_addr !== 2'd0) begin miscompares++; $display("FAIL rst_addr got %0d want 0", win_row_addr); end
    rst = 1'b0;
  endtask

  task automatic test_cw;
    int cyc;
    set_win(6'd0, 6'd0, 6'd0, 6'd0);
    run_op(16'b0100_0100_0100_0100, 1'b0, cyc);
    vectors++; if (cyc !== 7) begin miscompares++; $display("FAIL cw_latency got %0d want 7", cyc); end
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL cw_ok got %b want 1", ok); end
    vectors++; if (new_float !== 16'b0000_1111_0000_0000) begin miscompares++; $display("FAIL cw_nf got %b want 0000111100000000", new_float); end
    vectors++; if (kick !== 2'd0) begin miscompares++; $display("FAIL cw_kick got %0d want 0", kick); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cw_busy got %b want 0", busy); end
    vectors++; if (win_row_addr !== 2'd0) begin miscompares++; $display("FAIL cw_addr got %0d want 0", win_row_addr); end
    @(posedge clk); #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL cw_done_pulse got %b want 0", done); end
  endtask

  task automatic test_ccw;
    int cyc;
    set_win(6'd0, 6'd0, 6'd0, 6'd0);
    run_op(16'b0000_0111_0100_0000, 1'b1, cyc);
    vectors++; if (cyc !== 7) begin miscompares++; $display("FAIL ccw_latency got %0d want 7", cyc); end
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL ccw_ok got %b want 1", ok); end
    vectors++; if (new_float !== 16'b0100_0100_0110_0000) begin miscompares++; $display("FAIL ccw_nf got %b want 0100010001100000", new_float); end
    vectors++; if (kick !== 2'd0) begin miscompares++; $display("FAIL ccw_kick got %0d want 0", kick); end
  endtask

  task automatic test_kick_right;
    int cyc;
    logic [0:15] f, r;
    f = 16'b0000_0000_1110_0100;
    r = 16'b0100_1100_0100_0000;
    set_win(6'd0, 6'b010000, 6'd0, 6'd0);
    run_op(f, 1'b0, cyc);
    vectors++; if (cyc !== (KE ? 17 : 7)) begin miscompares++; $display("FAIL kr_latency got %0d want %0d", cyc, KE ? 17 : 7); end
    vectors++; if (ok !== KE) begin miscompares++; $display("FAIL kr_ok got %b want %b", ok, KE); end
    vectors++; if (new_float !== (KE ? r : f)) begin miscompares++; $display("FAIL kr_nf got %b want %b", new_float, KE ? r : f); end
    vectors++; if (kick !== (KE ? 2'd2 : 2'd0)) begin miscompares++; $display("FAIL kr_kick got %0d want %0d", kick, KE ? 2 : 0); end
  endtask

  task automatic test_kick_left;
    int cyc;
    logic [0:15] f, r;
    f = 16'b0100_0100_0100_0100;
    r = 16'b0000_1111_0000_0000;
    set_win(6'd0, 6'b000010, 6'd0, 6'd0);
    run_op(f, 1'b0, cyc);
    vectors++; if (cyc !== (KE ? 12 : 7)) begin miscompares++; $display("FAIL kl_latency got %0d want %0d", cyc, KE ? 12 : 7); end
    vectors++; if (ok !== KE) begin miscompares++; $display("FAIL kl_ok got %b want %b", ok, KE); end
    vectors++; if (new_float !== (KE ? r : f)) begin miscompares++; $display("FAIL kl_nf got %b want %b", new_float, KE ? r : f); end
    vectors++; if (kick !== (KE ? 2'd1 : 2'd0)) begin miscompares++; $display("FAIL kl_kick got %0d want %0d", kick, KE ? 1 : 0); end
  endtask

  task automatic test_full_window;
    int cyc;
    set_win(6'h3f, 6'h3f, 6'h3f, 6'h3f);
    run_op(16'b0000_0000_1110_0100, 1'b1, cyc);
    vectors++; if (cyc !== (KE ? 17 : 7)) begin miscompares++; $display("FAIL full_latency got %0d want %0d", cyc, KE ? 17 : 7); end
    vectors++; if (ok !== 1'b0) begin miscompares++; $display("FAIL full_ok got %b want 0", ok); end
    vectors++; if (new_float !== 16'b0000_0000_1110_0100) begin miscompares++; $display("FAIL full_nf got %b want 0000000011100100", new_float); end
    vectors++; if (kick !== 2'd0) begin miscompares++; $display("FAIL full_kick got %0d want 0", kick); end
    run_op(16'h0000, 1'b0, cyc);
    vectors++; if (cyc !== 7) begin miscompares++; $display("FAIL zero_latency got %0d want 7", cyc); end
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL zero_ok got %b want 1", ok); end
    vectors++; if (new_float !== 16'h0000) begin miscompares++; $display("FAIL zero_nf got %b want 0", new_float); end
  endtask

  task automatic test_reset_mid;
    int cyc, pulses;
    set_win(6'd0, 6'd0, 6'd0, 6'd0);
    float = 16'b0100_0100_0100_0100; direction = 1'b0; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (win_row_addr !== 2'd2) begin miscompares++; $display("FAIL mid_addr_pre got %0d want 2", win_row_addr); end
    rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b want 0", busy); end
    vectors++; if (ok !== 1'b0) begin miscompares++; $display("FAIL mid_ok got %b want 0", ok); end
    vectors++; if (new_float !== 16'h0) begin miscompares++; $display("FAIL mid_nf got %b want 0", new_float); end
    vectors++; if (win_row_addr !== 2'd0) begin miscompares++; $display("FAIL mid_addr got %0d want 0", win_row_addr); end
    #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (done) pulses++; end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL mid_no_done got %0d want 0", pulses); end
    run_op(16'b0000_0111_0100_0000, 1'b1, cyc);
    vectors++; if (cyc !== 7) begin miscompares++; $display("FAIL mid_after_latency got %0d want 7", cyc); end
    vectors++; if (new_float !== 16'b0100_0100_0110_0000) begin miscompares++; $display("FAIL mid_after_nf got %b want 0100010001100000", new_float); end
  endtask

  task automatic test_busy_ignore;
    int first, pulses;
    logic [0:15] nf_at;
    set_win(6'd0, 6'd0, 6'd0, 6'd0);
    float = 16'b0100_0100_0100_0100; direction = 1'b0; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bi_busy got %b want 1", busy); end
    float = 16'b0000_0000_1110_0100; direction = 1'b1; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    first = -1; pulses = 0; nf_at = '0;
    for (int i = 4; i < 34; i++) begin
      @(posedge clk); #1;
      if (done) begin pulses++; if (first < 0) begin first = i; nf_at = new_float; end end
    end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL bi_pulses got %0d want 1", pulses); end
    vectors++; if (first !== 7) begin miscompares++; $display("FAIL bi_latency got %0d want 7", first); end
    vectors++; if (nf_at !== 16'b0000_1111_0000_0000) begin miscompares++; $display("FAIL bi_nf got %b want 0000111100000000", nf_at); end
  endtask

  task automatic test_back_to_back;
    int d1, d2;
    set_win(6'd0, 6'd0, 6'd0, 6'd0);
    float = 16'b0100_0100_0100_0100; direction = 1'b0; req = 1'b1;
    @(posedge clk);
    d1 = -1; d2 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (d1 < 0) d1 = i;
        else begin d2 = i; req = 1'b0; break; end
      end
    end
    req = 1'b0;
    vectors++; if (d1 !== 7) begin miscompares++; $display("FAIL b2b_first got %0d want 7", d1); end
    vectors++; if (d2 !== 15) begin miscompares++; $display("FAIL b2b_second got %0d want 15", d2); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_cw();
    test_ccw();
    test_kick_right();
    test_kick_left();
    test_full_window();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
